uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver: 8 data bits, LSB first, no parity, one stop bit. One `i_RX` sample is taken per bit period, on each cycle where the bit-rate strobe `i_CLK_ENABLE` is high. The strobe comes from an upstream baud generator. The block sits between the pad-side RX line (already synchronised to `i_CLK`) and the byte consumer, which takes a byte on a one-cycle `o_RX_DONE` pulse.

## Interface
Parameters: none (frame format fixed at 8N1).

- `i_CLK`  in  1  system clock; all state updates on the rising edge.
- `i_RESET`  in  1  asynchronous, active-high reset.
- `i_CLK_ENABLE`  in  1  bit-rate strobe; one-cycle pulse per bit period; all sampling and state advance qualified by it.
- `i_RX`  in  1  serial line; idle high; pre-synchronised to `i_CLK`.
- `o_DATA`  out  8  last correctly framed byte; bit 0 is the first data bit received.
- `o_RX_DONE`  out  1  one-cycle pulse when a byte is received with a valid stop bit.
- `o_FRAMING_ERROR`  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- State register is 2 bits: IDLE=0, DATA=1, STOP=2. Encoding 3 is illegal and goes to IDLE on the next strobe.
- Internal registers:
  - `r_BIT_COUNT`: 4 bits, range 0..8.
  - `r_DATA_REG`: 8-bit shift register.
- IDLE:
  - On a strobe with `i_RX`=0, the start bit is accepted. Go to DATA, clear `r_BIT_COUNT` and `r_DATA_REG`.
  - `i_RX`=1 on a strobe: stay in IDLE.
- DATA:
  - Each strobe shifts `i_RX` into the MSB of `r_DATA_REG` (right shift) and increments `r_BIT_COUNT`.
  - After the 8th sample (count reaches 8), go to STOP. `r_DATA_REG` then holds the byte with its first bit at bit 0.
- STOP, on the next strobe:
  - `i_RX`=1: `o_DATA`←`r_DATA_REG`, pulse `o_RX_DONE`, go to IDLE.
  - `i_RX`=0: pulse `o_FRAMING_ERROR`, `o_DATA` unchanged, go to IDLE.
- After a framing error, IDLE treats a still-low line as a new start bit on the next strobe. No break detection.
- `o_RX_DONE` and `o_FRAMING_ERROR` are never high together.
- With no strobe, all state, count and data registers hold. The pulse outputs still self-clear.
- Reset (any time, including mid-frame): state=IDLE, `r_BIT_COUNT`=0, `r_DATA_REG`=0, `o_DATA`=0, `o_RX_DONE`=0, `o_FRAMING_ERROR`=0. A partial frame is discarded.

## Timing
- All outputs are registered.
- Start strobe S0. Data bits are sampled on strobes S1..S8 and the stop bit on S9.
- `o_RX_DONE` / `o_FRAMING_ERROR` rise on the `i_CLK` edge that samples S9. They are high for exactly one `i_CLK` cycle and clear on the next edge, regardless of `i_CLK_ENABLE`.
- `o_DATA` changes on the same edge as `o_RX_DONE` rises and holds until the next good frame or reset.
- Frame length: 10 strobes from start detection to done.
- Back-to-back frames: a start bit may be accepted on the strobe immediately after S9.
- Consecutive strobes on adjacent `i_CLK` cycles are legal; there is no minimum strobe spacing.
- Reset deassertion: the first strobe after release can be a start detect.

## Configuration
- `UART_RX_FORMAL_EN` defined: embedded formal properties are compiled in.
  - Assumption: `i_RESET` high in the first cycle.
  - Assertions:
    - state is never 3;
    - `r_BIT_COUNT` ≤ 8;
    - count is 0 in IDLE;
    - done and framing error are mutually exclusive;
    - pulse outputs last one cycle;
    - `o_DATA` changes only with `o_RX_DONE`;
    - all regs are 0 the cycle after reset.
  - Covers: a done and a framing error.
- Undefined: no property logic. Functional behaviour is identical either way.

## Test plan
- Reset mid-DATA (after 3 bits), then an idle line → all outputs 0, state IDLE, no pulse on subsequent strobes.
- Frame 0,[0,0,1,0,1,1,0,1],1 on consecutive strobes → one-cycle `o_RX_DONE` on the S9 edge, `o_DATA`=0xB4, `o_FRAMING_ERROR`=0.
- Same frame with stop bit 0 after a good 0x55 frame → `o_FRAMING_ERROR` pulse, no `o_RX_DONE`, `o_DATA` stays 0x55.
- Frame 0x3C with 5 idle `i_CLK` cycles (strobe low) between every strobe → `o_DATA`=0x3C, pulse still exactly one `i_CLK` wide.
- Back-to-back frames 0xFF then 0x00, second start on the strobe after the first stop → two `o_RX_DONE` pulses 10 strobes apart, `o_DATA` 0xFF then 0x00.
- Line held low for 20 strobes → framing error at S9, new frame started at S10, second framing error at S19.

Source files
------------

// File: rtl/uart_rx_if.sv
// Byte-side and line-side signal bundle for the 8N1 UART receiver.
// The receiver connects through the slave modport. The stimulus or line driver connects through the master modport.
interface uart_rx_if;
  logic       i_CLK_ENABLE;
  logic       i_RX;
  logic [7:0] o_DATA;
  logic       o_RX_DONE;
  logic       o_FRAMING_ERROR;

  modport slave (
    input  i_CLK_ENABLE,
    input  i_RX,
    output o_DATA,
    output o_RX_DONE,
    output o_FRAMING_ERROR
  );

  modport master (
    output i_CLK_ENABLE,
    output i_RX,
    input  o_DATA,
    input  o_RX_DONE,
    input  o_FRAMING_ERROR
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver that samples the line once per bit-rate strobe.
// Defining UART_RX_FORMAL_EN compiles in the embedded formal properties.
module uart_rx (
  input logic      i_CLK,
  input logic      i_RESET,
  uart_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2,
    BAD  = 2'd3
  } state_t;

  state_t     state_r, next_state_s;
  logic [3:0] r_BIT_COUNT, next_count_s;
  logic [7:0] r_DATA_REG, next_shift_s;
  logic [7:0] data_r, next_data_s;
  logic       done_r, done_s;
  logic       ferr_r, ferr_s;

  // Next-state, shift and pulse decode; nothing advances without a strobe
  always_comb begin
    next_state_s = state_r;
    next_count_s = r_BIT_COUNT;
    next_shift_s = r_DATA_REG;
    next_data_s  = data_r;
    done_s       = 1'b0;
    ferr_s       = 1'b0;
    if (bus.i_CLK_ENABLE) begin
      case (state_r)
        IDLE: begin
          if (!bus.i_RX) begin
            next_state_s = DATA;
            next_count_s = 4'd0;
            next_shift_s = 8'd0;
          end else begin
            next_state_s = IDLE;
          end
        end
        DATA: begin
          next_shift_s = {bus.i_RX, r_DATA_REG[7:1]};
          next_count_s = r_BIT_COUNT + 4'd1;
          if (r_BIT_COUNT == 4'd7) begin
            next_state_s = STOP;
          end else begin
            next_state_s = DATA;
          end
        end
        STOP: begin
          // Count returns to zero so it is always 0 while idle
          next_state_s = IDLE;
          next_count_s = 4'd0;
          if (bus.i_RX) begin
            next_data_s = r_DATA_REG;
            done_s      = 1'b1;
          end else begin
            ferr_s      = 1'b1;
          end
        end
        default: begin
          next_state_s = IDLE;
          next_count_s = 4'd0;
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // State, count, shift register and registered outputs
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_r     <= IDLE;
      r_BIT_COUNT <= 4'd0;
      r_DATA_REG  <= 8'd0;
      data_r      <= 8'd0;
      done_r      <= 1'b0;
      ferr_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      r_BIT_COUNT <= next_count_s;
      r_DATA_REG  <= next_shift_s;
      data_r      <= next_data_s;
      done_r      <= done_s;
      ferr_r      <= ferr_s;
    end
  end

  assign bus.o_DATA          = data_r;
  assign bus.o_RX_DONE       = done_r;
  assign bus.o_FRAMING_ERROR = ferr_r;

`ifdef UART_RX_FORMAL_EN
  logic past_valid_r = 1'b0;

  // Marks every cycle after the first, so $past is meaningful
  always_ff @(posedge i_CLK) begin
    past_valid_r <= 1'b1;
  end

  am_first_reset: assume property (@(posedge i_CLK) !past_valid_r |-> i_RESET);

  ap_no_bad_state: assert property (@(posedge i_CLK) disable iff (i_RESET) state_r != BAD);
  ap_count_range:  assert property (@(posedge i_CLK) disable iff (i_RESET) r_BIT_COUNT <= 4'd8);
  ap_idle_count:   assert property (@(posedge i_CLK) disable iff (i_RESET)
                                    (state_r == IDLE) |-> (r_BIT_COUNT == 4'd0));
  ap_exclusive:    assert property (@(posedge i_CLK) disable iff (i_RESET) !(done_r && ferr_r));
  ap_done_width:   assert property (@(posedge i_CLK) disable iff (i_RESET) done_r |=> !done_r);
  ap_ferr_width:   assert property (@(posedge i_CLK) disable iff (i_RESET) ferr_r |=> !ferr_r);
  ap_data_change:  assert property (@(posedge i_CLK) disable iff (i_RESET)
                                    (past_valid_r && !$stable(data_r)) |-> done_r);
  ap_reset_clear:  assert property (@(posedge i_CLK)
                                    (past_valid_r && $past(i_RESET)) |->
                                    (state_r == IDLE && r_BIT_COUNT == 4'd0 && r_DATA_REG == 8'd0 &&
                                     data_r == 8'd0 && !done_r && !ferr_r));

  cp_done: cover property (@(posedge i_CLK) done_r);
  cp_ferr: cover property (@(posedge i_CLK) ferr_r);
`else
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected frames are queued as they are driven and checked when a pulse appears.
module tb_uart_rx;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic prev_pulse = 1'b0;
  exp_t sb_q[$];

  uart_rx_if bus();

  uart_rx dut (
    .i_CLK   (clk),
    .i_RESET (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: pops the scoreboard on every done/error pulse
  always @(negedge clk) begin
    if (!rst && (bus.o_RX_DONE || bus.o_FRAMING_ERROR)) begin
      exp_t e;
      vectors++;
      if (bus.o_RX_DONE && bus.o_FRAMING_ERROR) begin
        miscompares++;
        $display("FAIL mon_exclusive: done=%b ferr=%b, required not both high", bus.o_RX_DONE, bus.o_FRAMING_ERROR);
      end
      vectors++;
      if (prev_pulse) begin
        miscompares++;
        $display("FAIL mon_width: pulse high on two consecutive cycles, required one");
      end
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL mon_unexpected: done=%b ferr=%b with nothing expected", bus.o_RX_DONE, bus.o_FRAMING_ERROR);
      end else begin
        e = sb_q.pop_front();
        vectors++;
        if (bus.o_FRAMING_ERROR !== e.err || bus.o_RX_DONE !== !e.err) begin
          miscompares++;
          $display("FAIL mon_kind: done=%b ferr=%b, required ferr=%b", bus.o_RX_DONE, bus.o_FRAMING_ERROR, e.err);
        end
        if (!e.err) begin
          vectors++;
          if (bus.o_DATA !== e.data) begin
            miscompares++;
            $display("FAIL mon_data: got %h, required %h", bus.o_DATA, e.data);
          end
        end
      end
    end
    prev_pulse <= bus.o_RX_DONE | bus.o_FRAMING_ERROR;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // One strobe carrying bit b, preceded by gap idle clock cycles; starts and ends at a negedge
  task automatic strobe(input logic b, input int gap);
    bus.i_RX = b;
    bus.i_CLK_ENABLE = 1'b0;
    repeat (gap) @(negedge clk);
    bus.i_CLK_ENABLE = 1'b1;
    @(negedge clk);
    bus.i_CLK_ENABLE = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    exp_t e;
    strobe(1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(d[i], gap);
    e.err  = ~stop;
    e.data = d;
    sb_q.push_back(e);
    strobe(stop, gap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_CLK_ENABLE = 1'b0;
    bus.i_RX = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.o_DATA !== 8'h00 || bus.o_RX_DONE !== 1'b0 || bus.o_FRAMING_ERROR !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_init: data=%h done=%b ferr=%b, required 00/0/0", bus.o_DATA, bus.o_RX_DONE, bus.o_FRAMING_ERROR);
    end
    rst = 1'b0;
    send_frame(8'hA5, 1'b1, 0);
    vectors++;
    if (bus.o_DATA !== 8'hA5) begin
      miscompares++;
      $display("FAIL reset_preframe: got %h, required a5", bus.o_DATA);
    end
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.o_DATA !== 8'h00 || bus.o_RX_DONE !== 1'b0 || bus.o_FRAMING_ERROR !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: data=%h done=%b ferr=%b, required 00/0/0", bus.o_DATA, bus.o_RX_DONE, bus.o_FRAMING_ERROR);
    end
    vectors++;
    if (dut.state_r !== 2'd0 || dut.r_BIT_COUNT !== 4'd0 || dut.r_DATA_REG !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_state: state=%0d count=%0d shift=%h, required 0/0/00", dut.state_r, dut.r_BIT_COUNT, dut.r_DATA_REG);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      strobe(1'b1, 0);
      vectors++;
      if (bus.o_RX_DONE !== 1'b0 || bus.o_FRAMING_ERROR !== 1'b0 || bus.o_DATA !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_idle_line: strobe %0d done=%b ferr=%b data=%h, required 0/0/00", i, bus.o_RX_DONE, bus.o_FRAMING_ERROR, bus.o_DATA);
      end
    end
  endtask

  task automatic test_good_frame();
    send_frame(8'hB4, 1'b1, 0);
    vectors++;
    if (bus.o_RX_DONE !== 1'b1 || bus.o_FRAMING_ERROR !== 1'b0 || bus.o_DATA !== 8'hB4) begin
      miscompares++;
      $display("FAIL good_s9: done=%b ferr=%b data=%h, required 1/0/b4", bus.o_RX_DONE, bus.o_FRAMING_ERROR, bus.o_DATA);
    end
    @(negedge clk);
    vectors++;
    if (bus.o_RX_DONE !== 1'b0 || bus.o_DATA !== 8'hB4) begin
      miscompares++;
      $display("FAIL good_after: done=%b data=%h, required 0/b4", bus.o_RX_DONE, bus.o_DATA);
    end
  endtask

  task automatic test_framing_error();
    send_frame(8'h55, 1'b1, 0);
    send_frame(8'hB4, 1'b0, 0);
    vectors++;
    if (bus.o_FRAMING_ERROR !== 1'b1 || bus.o_RX_DONE !== 1'b0 || bus.o_DATA !== 8'h55) begin
      miscompares++;
      $display("FAIL ferr_s9: done=%b ferr=%b data=%h, required 0/1/55", bus.o_RX_DONE, bus.o_FRAMING_ERROR, bus.o_DATA);
    end
    @(negedge clk);
    vectors++;
    if (bus.o_FRAMING_ERROR !== 1'b0 || bus.o_DATA !== 8'h55) begin
      miscompares++;
      $display("FAIL ferr_after: ferr=%b data=%h, required 0/55", bus.o_FRAMING_ERROR, bus.o_DATA);
    end
    strobe(1'b1, 0);
  endtask

  task automatic test_slow_strobe();
    send_frame(8'h3C, 1'b1, 5);
    vectors++;
    if (bus.o_RX_DONE !== 1'b1 || bus.o_DATA !== 8'h3C) begin
      miscompares++;
      $display("FAIL slow_s9: done=%b data=%h, required 1/3c", bus.o_RX_DONE, bus.o_DATA);
    end
    @(negedge clk);
    vectors++;
    if (bus.o_RX_DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL slow_width: done=%b one cycle later, required 0", bus.o_RX_DONE);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    send_frame(8'hFF, 1'b1, 0);
    t1 = cyc;
    vectors++;
    if (bus.o_RX_DONE !== 1'b1 || bus.o_DATA !== 8'hFF) begin
      miscompares++;
      $display("FAIL b2b_first: done=%b data=%h, required 1/ff", bus.o_RX_DONE, bus.o_DATA);
    end
    send_frame(8'h00, 1'b1, 0);
    t2 = cyc;
    vectors++;
    if (bus.o_RX_DONE !== 1'b1 || bus.o_DATA !== 8'h00) begin
      miscompares++;
      $display("FAIL b2b_second: done=%b data=%h, required 1/00", bus.o_RX_DONE, bus.o_DATA);
    end
    vectors++;
    if (t2 - t1 !== 10) begin
      miscompares++;
      $display("FAIL b2b_spacing: %0d cycles between pulses, required 10", t2 - t1);
    end
  endtask

  task automatic test_line_low();
    exp_t e;
    e.err  = 1'b1;
    e.data = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (i == 9 || i == 19) sb_q.push_back(e);
      strobe(1'b0, 0);
      if (i == 9 || i == 19) begin
        vectors++;
        if (bus.o_FRAMING_ERROR !== 1'b1 || bus.o_RX_DONE !== 1'b0 || bus.o_DATA !== 8'h00) begin
          miscompares++;
          $display("FAIL low_ferr_s%0d: ferr=%b done=%b data=%h, required 1/0/00", i, bus.o_FRAMING_ERROR, bus.o_RX_DONE, bus.o_DATA);
        end
      end
    end
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    vectors++;
    if (dut.state_r !== 2'd0) begin
      miscompares++;
      $display("FAIL low_recover: state=%0d, required 0", dut.state_r);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_framing_error();
    test_slow_strobe();
    test_back_to_back();
    test_line_low();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb_q.size() !== 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d expected pulses never seen, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
